alarm_ring_controller: RTL
==========================

Name: alarm_ring_controller

Overview:
Sequences the alarm event for the digital clock and arbitrates the shared synchronized buttons between the mode modules and the alarm.
- Detects the alarm-match edge, drives the buzzer and digit flicker, and runs ring/snooze timing.
- While ringing, it captures all buttons. Otherwise it forwards them to the clock/alarm/stopwatch logic and the mode register.
- It sits between the signal synchronizer and the mode modules, and replaces the raw time-equality ringing signal.

Parameters:
TICK_DIV, 2000000, clk cycles per 1 s tick (2 MHz clock)
RING_SEC, 60, seconds of ringing before auto-snooze
SNOOZE_SEC, 300, seconds of snooze before re-ring
MAX_SNOOZE, 3, max snoozes per alarm event; value 1..3
BEEP_DIV, 250000, clk cycles per buzzer on/off half-period

Ports:
clk  in  1  2 MHz system clock
reset  in  1  asynchronous, active-high
real_time  in  21  current packed time from clock mode
alarm_time  in  21  packed alarm time from alarm mode
alarm_en  in  1  alarm armed
set_active  in  1  clock or alarm mode currently in setting state
btn_mode, btn_set, btn_op1, btn_op2, btn_free  in  1 each  single-cycle synchronized button pulses
fwd_mode, fwd_set, fwd_op1, fwd_op2, fwd_free  out  1 each  forwarded button pulses
ring  out  1  buzzer drive
flick_mask  out  6  digit flicker override, OR-ed with the mode flick mask downstream
snooze_cnt  out  2  snoozes taken in current event
state  out  2  IDLE=0, RING=1, SNOOZE=2

Behaviour:
- Reset (async): state=IDLE, all fwd_*=0, ring=0, flick_mask=0, snooze_cnt=0, prescaler=0, sec_cnt=0, beep phase=0, match_d=0.
- Prescaler:
  - Free-running count 0..TICK_DIV-1.
  - tick is a 1-cycle pulse when count==TICK_DIV-1.
  - It is never cleared except by reset.
- Trigger:
  - match=(real_time==alarm_time), registered as match_d.
  - trig = match & ~match_d & alarm_en & ~set_active.
  - This gives one trigger per matching second.
- IDLE:
  - trig -> RING; sec_cnt=0, snooze_cnt=0, beep phase=1.
- RING:
  - ring = beep phase; the beep phase toggles every BEEP_DIV cycles, with its counter restarted on RING entry.
  - flick_mask=6'b111111.
  - sec_cnt increments on tick.
  - Transitions, in priority order:
    1. alarm_en=0 -> IDLE.
    2. btn_set -> IDLE (dismiss).
    3. btn_op1 -> SNOOZE if snooze_cnt<MAX_SNOOZE, else IDLE.
    4. tick with sec_cnt==RING_SEC-1 -> same rule as btn_op1.
  - The SNOOZE transition increments snooze_cnt and clears sec_cnt.
- SNOOZE:
  - ring=0, flick_mask=0.
  - sec_cnt increments on tick.
  - alarm_en=0 or btn_set -> IDLE (cancel).
  - tick with sec_cnt==SNOOZE_SEC-1 -> RING; sec_cnt=0, beep phase=1.
- Transitions to IDLE clear snooze_cnt.
- trig in RING or SNOOZE is ignored.
- Button arbitration:
  - fwd_x is registered: fwd_x <= btn_x & (state != RING), using the state before the current-cycle update. Latency is 1 cycle.
  - A button that causes RING exit is consumed and never forwarded.
  - btn_op2, btn_mode and btn_free during RING are swallowed with no effect.
- Simultaneous events:
  - Button vs timeout in the same cycle: the button wins.
  - btn_set with btn_op1: dismiss wins.
  - trig coinciding with reset: reset wins.
- ring and flick_mask are registered outputs that follow state one cycle after the transition.
- sec_cnt width is clog2(max(RING_SEC,SNOOZE_SEC)+1); it saturates and never wraps.

Decomposition:
- Package clock_pkg:
  - state encoding (ST_IDLE/ST_RING/ST_SNOOZE)
  - TIME_W=21
  - FLICK_W=6
  - FLICK_ALL=6'b111111
- One sub-module: tick_prescaler (parameter DIV; ports clk, reset, tick), instanced twice:
  - 1 s tick, free-running
  - beep toggle, with a synchronous restart input

Test Plan:
Use TICK_DIV=4, RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=2, BEEP_DIV=2 for all scenarios.
1. alarm_en=1, alarm_time=real_time edge -> state=RING next cycle; flick_mask=3F; ring toggles every 2 cycles; match held 4+ cycles gives only one trigger.
2. RING, btn_set pulse -> state=IDLE, ring=0, fwd_set stays 0. Then btn_op2 in IDLE -> fwd_op2=1 exactly 1 cycle later.
3. RING, no buttons -> SNOOZE after 3 ticks with snooze_cnt=1. RING again after 2 ticks. Second timeout gives snooze_cnt=2. Third timeout -> IDLE, snooze_cnt=0.
4. RING, btn_set and btn_op1 in the same cycle -> IDLE. RING with btn_op1 on the same cycle as the timeout tick -> SNOOZE, snooze_cnt incremented exactly once.
5. set_active=1 during the match edge -> no trigger. alarm_en dropped in SNOOZE -> IDLE next cycle.
6. Reset asserted asynchronously mid-RING -> all outputs 0 immediately. After release, a new match edge triggers RING normally.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock alarm path.
// Holds the alarm controller state encoding, the packed time width and the
// digit flicker mask constants used by the display override.
package clock_pkg;

  localparam int TIME_W  = 21;
  localparam int FLICK_W = 6;

  localparam logic [FLICK_W-1:0] FLICK_ALL = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV cycle counter producing a one-cycle tick pulse.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high; clears the count
//   restart  synchronous restart: count returns to 0 on the next edge
//   tick     high for the single cycle in which the count equals DIV-1
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Wrap at DIV-1; a restart takes precedence over the wrap so the next
  // full period always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm event sequencer and button arbiter for the digital clock.
// Detects the rising edge of the alarm time match, rings the buzzer with a
// beep pattern and flickers all digits, and runs ring/snooze timing. While
// ringing it captures all buttons; otherwise it forwards them to the modes.
// Ports:
//   clk, reset              2 MHz clock, asynchronous active-high reset
//   real_time, alarm_time   packed current time and alarm time
//   alarm_en                alarm armed
//   set_active              a mode is in its setting state (blocks trigger)
//   btn_*                   single-cycle synchronized button pulses
//   fwd_*                   forwarded button pulses, one cycle later
//   ring                    buzzer drive
//   flick_mask              digit flicker override
//   snooze_cnt              snoozes taken in the current alarm event
//   state                   IDLE=0, RING=1, SNOOZE=2
module alarm_ring_controller
  import clock_pkg::*;
#(
  parameter int TICK_DIV   = 2000000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int BEEP_DIV   = 250000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TIME_W-1:0]  real_time,
  input  logic [TIME_W-1:0]  alarm_time,
  input  logic               alarm_en,
  input  logic               set_active,
  input  logic               btn_mode,
  input  logic               btn_set,
  input  logic               btn_op1,
  input  logic               btn_op2,
  input  logic               btn_free,
  output logic               fwd_mode,
  output logic               fwd_set,
  output logic               fwd_op1,
  output logic               fwd_op2,
  output logic               fwd_free,
  output logic               ring,
  output logic [FLICK_W-1:0] flick_mask,
  output logic [1:0]         snooze_cnt,
  output logic [1:0]         state
);

  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);

  localparam logic [SEC_W-1:0] SEC_TOP      = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] RING_LAST    = SEC_W'(RING_SEC - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST  = SEC_W'(SNOOZE_SEC - 1);
  localparam logic [1:0]       SNOOZE_LIMIT = 2'(MAX_SNOOZE);

  state_t           state_q, state_n;
  logic [SEC_W-1:0] sec_q, sec_n, sec_sat;
  logic [1:0]       snz_q, snz_n;
  logic             phase_q, phase_n;
  logic             beep_restart;
  logic             match_d;
  logic             match;
  logic             trig;
  logic             tick;
  logic             beep_tick;

  // One-second timebase; free-running so the alarm never disturbs it.
  tick_prescaler #(.DIV(TICK_DIV)) u_sec_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (1'b0),
    .tick    (tick)
  );

  // Beep half-period timer, restarted whenever RING is entered so every ring
  // burst starts with a full "on" half-period.
  tick_prescaler #(.DIV(BEEP_DIV)) u_beep_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (beep_restart),
    .tick    (beep_tick)
  );

  assign match   = (real_time == alarm_time);
  assign trig    = match & ~match_d & alarm_en & ~set_active;
  assign sec_sat = (sec_q == SEC_TOP) ? sec_q : sec_q + 1'b1;

  // Next-state logic. Exits from RING are prioritised: disarm, dismiss,
  // snooze button, then timeout, so a button always beats a coincident tick.
  // Both snooze paths share the MAX_SNOOZE check and end the event at the cap.
  always_comb begin
    state_n      = state_q;
    sec_n        = sec_q;
    snz_n        = snz_q;
    phase_n      = phase_q;
    beep_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_n      = ST_RING;
          sec_n        = '0;
          snz_n        = '0;
          phase_n      = 1'b1;
          beep_restart = 1'b1;
        end
      end
      ST_RING: begin
        if (tick) sec_n = sec_sat;
        if (beep_tick) phase_n = ~phase_q;
        if (!alarm_en || btn_set) begin
          state_n = ST_IDLE;
          snz_n   = '0;
        end else if (btn_op1 || (tick && sec_q == RING_LAST)) begin
          if (snz_q < SNOOZE_LIMIT) begin
            state_n = ST_SNOOZE;
            snz_n   = snz_q + 2'd1;
            sec_n   = '0;
          end else begin
            state_n = ST_IDLE;
            snz_n   = '0;
          end
        end
      end
      ST_SNOOZE: begin
        if (tick) sec_n = sec_sat;
        if (!alarm_en || btn_set) begin
          state_n = ST_IDLE;
          snz_n   = '0;
        end else if (tick && sec_q == SNOOZE_LAST) begin
          state_n      = ST_RING;
          sec_n        = '0;
          phase_n      = 1'b1;
          beep_restart = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        snz_n   = '0;
      end
    endcase
  end

  // FSM and timing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      snz_q   <= '0;
      phase_q <= 1'b0;
      match_d <= 1'b0;
    end else begin
      state_q <= state_n;
      sec_q   <= sec_n;
      snz_q   <= snz_n;
      phase_q <= phase_n;
      match_d <= match;
    end
  end

  // Registered outputs follow the pre-update state, so the buzzer and flicker
  // trail the state by one cycle and a button that ends RING is never
  // forwarded to the modes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring       <= 1'b0;
      flick_mask <= '0;
      fwd_mode   <= 1'b0;
      fwd_set    <= 1'b0;
      fwd_op1    <= 1'b0;
      fwd_op2    <= 1'b0;
      fwd_free   <= 1'b0;
    end else begin
      ring       <= (state_q == ST_RING) & phase_q;
      flick_mask <= (state_q == ST_RING) ? FLICK_ALL : '0;
      fwd_mode   <= btn_mode & (state_q != ST_RING);
      fwd_set    <= btn_set  & (state_q != ST_RING);
      fwd_op1    <= btn_op1  & (state_q != ST_RING);
      fwd_op2    <= btn_op2  & (state_q != ST_RING);
      fwd_free   <= btn_free & (state_q != ST_RING);
    end
  end

  assign snooze_cnt = snz_q;
  assign state      = state_q;

endmodule
